// File: rtl/matrix_unloader.sv
// Result-side streaming unloader: captures a result matrix and its dimensions in one
// handshake, then emits the elements row-major over a valid/ready stream.
module matrix_unloader #(
    parameter int MAX_R  = 4,
    parameter int MAX_C  = 4,
    parameter int ELEM_W = 128
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            load_valid,
    output logic                            load_ready,
    input  logic [3:0]                      R,
    input  logic [3:0]                      C,
    input  logic [MAX_R*MAX_C*ELEM_W-1:0]   rslt_flat,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ELEM_W-1:0]               out_data,
    output logic [3:0]                      out_row,
    output logic [3:0]                      out_col,
    output logic                            out_last,
    output logic                            dim_err
);

    localparam int         N     = MAX_R * MAX_C;
    localparam int         IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0] R_LIM = 4'(MAX_R);
    localparam logic [3:0] C_LIM = 4'(MAX_C);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state, state_nxt;
    logic [ELEM_W-1:0] mem [N];
    logic [3:0]        r_q, c_q, row, col;
    logic              dims_ok, accept, xfer, row_end, at_last;
    logic [IDX_W-1:0]  idx;

    always_comb begin
        dims_ok = (R != '0) && (R <= R_LIM) && (C != '0) && (C <= C_LIM);
        accept  = (state == IDLE) && load_valid && dims_ok;
        xfer    = (state == STREAM) && out_ready;
        row_end = (col == c_q - 4'd1);
        at_last = row_end && (row == r_q - 4'd1);
        idx     = IDX_W'(32'(row) * 32'(MAX_C) + 32'(col));
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)            state_nxt = STREAM;
            STREAM:  if (xfer && at_last)   state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Output logic; data is forced to zero outside STREAM so idle outputs are deterministic
    always_comb begin
        load_ready = (state == IDLE);
        out_valid  = (state == STREAM);
        out_data   = (state == STREAM) ? mem[idx] : '0;
        out_row    = row;
        out_col    = col;
        out_last   = (state == STREAM) && at_last;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_q     <= '0;
            c_q     <= '0;
            row     <= '0;
            col     <= '0;
            dim_err <= 1'b0;
        end else begin
            dim_err <= (state == IDLE) && load_valid && !dims_ok;
            if (accept) begin
                r_q <= R;
                c_q <= C;
                row <= '0;
                col <= '0;
            end else if (xfer) begin
                if (at_last) begin
                    row <= '0;
                    col <= '0;
                end else if (row_end) begin
                    row <= row + 4'd1;
                    col <= '0;
                end else begin
                    col <= col + 4'd1;
                end
            end
        end
    end

    // Element storage needs no reset: it is only read after a successful capture
    always_ff @(posedge CLK) begin
        if (accept) begin
            for (int unsigned k = 0; k < N; k++)
                mem[k] <= rslt_flat[k*ELEM_W +: ELEM_W];
        end
    end

endmodule

// File: tb/tb_matrix_unloader.sv
// Self-checking bench for matrix_unloader: directed scenarios plus randomized matrices
// checked against a row-major beat list built from a plain 2-D array.
module tb_matrix_unloader;

    localparam int MR = 4, MC = 4, EW = 128;
    localparam int FLAT_W = MR * MC * EW;
    localparam int LIMIT = 100;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic [3:0]        R = '0, C = '0;
    logic [FLAT_W-1:0] rslt_flat = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [EW-1:0]     out_data;
    logic [3:0]        out_row, out_col;
    logic              out_last;
    logic              dim_err;

    typedef struct {
        logic [EW-1:0] data;
        logic [3:0]    row;
        logic [3:0]    col;
        logic          last;
    } beat_t;

    logic [EW-1:0] m [MR][MC];
    beat_t         exp_q[$];
    int            total = 0;
    int            bad = 0;

    matrix_unloader #(.MAX_R(MR), .MAX_C(MC), .ELEM_W(EW)) dut (
        .CLK(CLK), .RST_N(RST_N), .load_valid(load_valid), .load_ready(load_ready),
        .R(R), .C(C), .rslt_flat(rslt_flat), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .dim_err(dim_err)
    );

    initial forever #5 CLK = ~CLK;

    function automatic logic [FLAT_W-1:0] pack();
        logic [FLAT_W-1:0] f;
        f = '0;
        for (int i = 0; i < MR; i++)
            for (int j = 0; j < MC; j++)
                f[(i*MC+j)*EW +: EW] = m[i][j];
        return f;
    endfunction

    // Reference: the beats a sink must see, in row-major order
    function automatic void build_exp(input int r, input int c);
        exp_q.delete();
        for (int i = 0; i < r; i++)
            for (int j = 0; j < c; j++)
                exp_q.push_back('{m[i][j], 4'(i), 4'(j), (i == r-1) && (j == c-1)});
    endfunction

    function automatic void clear_m();
        for (int i = 0; i < MR; i++)
            for (int j = 0; j < MC; j++)
                m[i][j] = '0;
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the accepting edge
    task automatic do_load(input logic [3:0] r, input logic [3:0] c);
        R = r; C = c; rslt_flat = pack(); load_valid = 1'b1;
        @(posedge CLK); #1;
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if (load_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_row !== '0 ||
            out_col !== '0 || out_last !== 1'b0 || dim_err !== 1'b0) begin
            bad++;
            $display("FAIL reset: ready=%b valid=%b data=%0h row=%0d col=%0d last=%b err=%b, want 1 0 0 0 0 0 0",
                     load_ready, out_valid, out_data, out_row, out_col, out_last, dim_err);
        end
        RST_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_2x2();
        int cyc = 0;
        clear_m();
        m[0][0] = 19; m[0][1] = 22; m[1][0] = 43; m[1][1] = 50;
        build_exp(2, 2);
        out_ready = 1'b1;
        do_load(4'd2, 4'd2);
        while (exp_q.size() != 0 && cyc < LIMIT) begin
            @(negedge CLK);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0].data || out_row !== exp_q[0].row ||
                out_col !== exp_q[0].col || out_last !== exp_q[0].last) begin
                bad++;
                $display("FAIL 2x2 beat: valid=%b data=%0d row=%0d col=%0d last=%b, want 1 %0d %0d %0d %b",
                         out_valid, out_data, out_row, out_col, out_last,
                         exp_q[0].data, exp_q[0].row, exp_q[0].col, exp_q[0].last);
            end
            void'(exp_q.pop_front());
            @(posedge CLK); #1; cyc++;
        end
        @(negedge CLK);
        total++;
        if (load_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL 2x2 idle: ready=%b valid=%b, want 1 0", load_ready, out_valid);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_3x4_stall();
        int cyc = 0;
        clear_m();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = EW'(16*i + j);
        build_exp(3, 4);
        do_load(4'd3, 4'd4);
        while (exp_q.size() != 0 && cyc < LIMIT) begin
            out_ready = (cyc % 2 == 0);
            @(negedge CLK);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0].data || out_row !== exp_q[0].row ||
                out_col !== exp_q[0].col || out_last !== exp_q[0].last) begin
                bad++;
                $display("FAIL 3x4 beat (ready=%b): valid=%b data=%0d row=%0d col=%0d last=%b, want 1 %0d %0d %0d %b",
                         out_ready, out_valid, out_data, out_row, out_col, out_last,
                         exp_q[0].data, exp_q[0].row, exp_q[0].col, exp_q[0].last);
            end
            if (out_ready) void'(exp_q.pop_front());
            @(posedge CLK); #1; cyc++;
        end
        total++;
        if (exp_q.size() != 0 || cyc != 23) begin
            bad++;
            $display("FAIL 3x4 count: left=%0d cycles=%0d, want 0 23", exp_q.size(), cyc);
        end
        out_ready = 1'b0;
        @(negedge CLK);
        total++;
        if (out_valid !== 1'b0 || load_ready !== 1'b1) begin
            bad++;
            $display("FAIL 3x4 idle: valid=%b ready=%b, want 0 1", out_valid, load_ready);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_1x1_back_to_back();
        clear_m();
        m[0][0] = 'hDEADBEEF;
        out_ready = 1'b1;
        do_load(4'd1, 4'd1);
        @(negedge CLK);
        total++;
        if (out_valid !== 1'b1 || out_data !== EW'('hDEADBEEF) || out_last !== 1'b1) begin
            bad++;
            $display("FAIL 1x1 first: valid=%b data=%0h last=%b, want 1 deadbeef 1", out_valid, out_data, out_last);
        end
        @(posedge CLK); #1;
        m[0][0] = 'h1234;
        R = 4'd1; C = 4'd1; rslt_flat = pack(); load_valid = 1'b1;
        @(negedge CLK);
        total++;
        if (load_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL 1x1 bubble: ready=%b valid=%b, want 1 0", load_ready, out_valid);
        end
        @(posedge CLK); #1;
        load_valid = 1'b0;
        @(negedge CLK);
        total++;
        if (out_valid !== 1'b1 || out_data !== EW'('h1234) || out_last !== 1'b1) begin
            bad++;
            $display("FAIL 1x1 second: valid=%b data=%0h last=%b, want 1 1234 1", out_valid, out_data, out_last);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        total++;
        if (out_valid !== 1'b0 || load_ready !== 1'b1) begin
            bad++;
            $display("FAIL 1x1 end: valid=%b ready=%b, want 0 1", out_valid, load_ready);
        end
        out_ready = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_illegal_dims();
        logic [3:0] rs [3];
        logic [3:0] cs [3];
        rs = '{4'd0, 4'd5, 4'd2};
        cs = '{4'd2, 4'd1, 4'd9};
        for (int k = 0; k < 3; k++) begin
            R = rs[k]; C = cs[k]; load_valid = 1'b1;
            @(posedge CLK); #1;
            load_valid = 1'b0;
            @(negedge CLK);
            total++;
            if (dim_err !== 1'b1 || out_valid !== 1'b0 || load_ready !== 1'b1) begin
                bad++;
                $display("FAIL illegal R=%0d C=%0d: err=%b valid=%b ready=%b, want 1 0 1",
                         rs[k], cs[k], dim_err, out_valid, load_ready);
            end
            @(posedge CLK); #1;
            @(negedge CLK);
            total++;
            if (dim_err !== 1'b0 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL illegal pulse R=%0d C=%0d: err=%b valid=%b, want 0 0", rs[k], cs[k], dim_err, out_valid);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_capture_independence();
        int cyc = 0;
        clear_m();
        m[0][0] = 100; m[0][1] = 101; m[1][0] = 102; m[1][1] = 103;
        m[2][2] = 999;
        build_exp(2, 2);
        out_ready = 1'b1;
        do_load(4'd2, 4'd2);
        rslt_flat = ~rslt_flat; R = 4'd4; C = 4'd4;
        while (exp_q.size() != 0 && cyc < LIMIT) begin
            @(negedge CLK);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0].data || out_row !== exp_q[0].row ||
                out_col !== exp_q[0].col || out_last !== exp_q[0].last) begin
                bad++;
                $display("FAIL capture beat: valid=%b data=%0h row=%0d col=%0d last=%b, want 1 %0h %0d %0d %b",
                         out_valid, out_data, out_row, out_col, out_last,
                         exp_q[0].data, exp_q[0].row, exp_q[0].col, exp_q[0].last);
            end
            void'(exp_q.pop_front());
            @(posedge CLK); #1; cyc++;
        end
        @(negedge CLK);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL capture end: valid=%b, want 0", out_valid);
        end
        out_ready = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_mid_reset();
        int cyc = 0;
        clear_m();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = EW'(1000 + 4*i + j);
        build_exp(4, 4);
        out_ready = 1'b1;
        do_load(4'd4, 4'd4);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0].data || out_col !== exp_q[0].col) begin
                bad++;
                $display("FAIL abort pre-beat: valid=%b data=%0d col=%0d, want 1 %0d %0d",
                         out_valid, out_data, out_col, exp_q[0].data, exp_q[0].col);
            end
            void'(exp_q.pop_front());
            @(posedge CLK); #1;
        end
        RST_N = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || load_ready !== 1'b1 || out_row !== '0 || out_col !== '0) begin
            bad++;
            $display("FAIL abort async: valid=%b ready=%b row=%0d col=%0d, want 0 1 0 0",
                     out_valid, load_ready, out_row, out_col);
        end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort release: valid=%b, want 0", out_valid);
        end
        @(posedge CLK); #1;
        clear_m();
        m[0][0] = 1; m[0][1] = 2; m[1][0] = 3; m[1][1] = 4;
        build_exp(2, 2);
        do_load(4'd2, 4'd2);
        while (exp_q.size() != 0 && cyc < LIMIT) begin
            @(negedge CLK);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0].data || out_row !== exp_q[0].row ||
                out_col !== exp_q[0].col || out_last !== exp_q[0].last) begin
                bad++;
                $display("FAIL after-abort beat: valid=%b data=%0d row=%0d col=%0d last=%b, want 1 %0d %0d %0d %b",
                         out_valid, out_data, out_row, out_col, out_last,
                         exp_q[0].data, exp_q[0].row, exp_q[0].col, exp_q[0].last);
            end
            void'(exp_q.pop_front());
            @(posedge CLK); #1; cyc++;
        end
        @(negedge CLK);
        total++;
        if (out_valid !== 1'b0 || load_ready !== 1'b1) begin
            bad++;
            $display("FAIL after-abort end: valid=%b ready=%b, want 0 1", out_valid, load_ready);
        end
        out_ready = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int r, c, cyc, beats;
            r = $urandom_range(1, MR);
            c = $urandom_range(1, MC);
            for (int i = 0; i < MR; i++)
                for (int j = 0; j < MC; j++)
                    m[i][j] = {$urandom, $urandom, $urandom, $urandom};
            build_exp(r, c);
            cyc = 0; beats = 0;
            do_load(4'(r), 4'(c));
            while (exp_q.size() != 0 && cyc < LIMIT) begin
                out_ready = ($urandom_range(0, 9) < 7);
                @(negedge CLK);
                total++;
                if (out_valid !== 1'b1 || out_data !== exp_q[0].data || out_row !== exp_q[0].row ||
                    out_col !== exp_q[0].col || out_last !== exp_q[0].last) begin
                    bad++;
                    $display("FAIL random %0dx%0d beat: valid=%b data=%0h row=%0d col=%0d last=%b, want 1 %0h %0d %0d %b",
                             r, c, out_valid, out_data, out_row, out_col, out_last,
                             exp_q[0].data, exp_q[0].row, exp_q[0].col, exp_q[0].last);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
                @(posedge CLK); #1; cyc++;
            end
            out_ready = 1'b0;
            @(negedge CLK);
            total++;
            if (beats != r*c || out_valid !== 1'b0 || load_ready !== 1'b1) begin
                bad++;
                $display("FAIL random %0dx%0d end: beats=%0d valid=%b ready=%b, want %0d 0 1",
                         r, c, beats, out_valid, load_ready, r*c);
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        clear_m();
        test_reset();
        test_2x2();
        test_3x4_stall();
        test_1x1_back_to_back();
        test_illegal_dims();
        test_capture_independence();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_unloader.md
# matrix_unloader

Result-side streaming unloader for the matrix multiplier. It captures a completed result matrix and its dimensions in one handshake. It then emits the elements one per beat in row-major order over a valid/ready stream, the inverse of the flat-array loader that feeds the multiplier. It sits between the multiplier's result array and the chip's output path/testbench sink.

## Interface

Parameters:
- MAX_R, 4, maximum supported row count
- MAX_C, 4, maximum supported column count
- ELEM_W, 128, width of one result element (matches multiplier accumulator width)

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- load_valid  in  1  result matrix and dimensions are presented
- load_ready  out  1  unloader can accept a matrix
- R  in  4  result row count
- C  in  4  result column count
- rslt_flat  in  MAX_R*MAX_C*ELEM_W  packed result; element (i,j) at slice index i*MAX_C+j, bits [(idx+1)*ELEM_W-1 : idx*ELEM_W]
- out_valid  out  1  out_data holds a valid element
- out_ready  in  1  sink accepts the current element
- out_data  out  ELEM_W  current element
- out_row  out  4  row index of out_data
- out_col  out  4  column index of out_data
- out_last  out  1  current element is (R-1,C-1)
- dim_err  out  1  one-cycle pulse: a load was rejected for illegal dimensions

## Operation

- FSM states:
  - IDLE: load_ready=1, out_valid=0.
  - STREAM: load_ready=0, out_valid=1.
- IDLE, load_valid=1:
  - If 1<=R<=MAX_R and 1<=C<=MAX_C: register rslt_flat, R and C; clear the row/col counters; go to STREAM.
  - Otherwise: pulse dim_err for one cycle, capture nothing, stay IDLE.
- STREAM:
  - out_data = stored element at (row,col). out_row=row, out_col=col. out_last = (row==R-1 && col==C-1).
  - A transfer occurs when out_valid && out_ready.
  - On a transfer with col<C-1: col++.
  - On a transfer with col==C-1 and row<R-1: col=0, row++.
  - On a transfer with out_last: go to IDLE. Counters return to 0.
  - With no transfer, out_data, out_row, out_col and out_last hold stable; out_valid stays 1 (no retraction).
- Captured data is independent of later input changes. rslt_flat, R and C may change freely after the accepting cycle.
- Elements outside R×C in rslt_flat are ignored.
- load_valid is ignored outside IDLE. The source must hold it until load_ready.
- Dimensions are unsigned. R and C values above MAX_R/MAX_C are errors, not truncated.

## Timing

- Reset values: state IDLE, load_ready=1, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, dim_err=0, storage contents don't-care.
- RST_N low at any time, including mid-stream, aborts immediately (asynchronously). No further beats of the aborted matrix are emitted after release.
- Load accepted at edge N: out_valid=1 with element (0,0) after edge N.
- With out_ready held 1, one element per cycle. R*C elements occupy R*C consecutive cycles.
- After the last transfer: one IDLE cycle (load_ready=1). The earliest next load is accepted on that cycle, so back-to-back matrices have a one-cycle bubble.
- dim_err is high for exactly the cycle after the rejected load.
- out_ready toggling never skips or duplicates elements. The total beat count always equals R*C.

## Test plan

- 2x2 load, R=2, C=2, elements [[19,22],[43,50]], out_ready=1 -> beats 19,22,43,50 on 4 consecutive cycles; (row,col)=(0,0),(0,1),(1,0),(1,1); out_last only on 50; then load_ready=1.
- 3x4 load with element(i,j)=16*i+j and out_ready toggling 1,0,1,0… -> 12 beats 0,1,2,3,16…,35 in order; data stable on stalled cycles; out_last on 35 only.
- 1x1 load, value 0xDEADBEEF -> single beat with out_last=1; back to IDLE; a second 1x1 load is accepted on the very next cycle.
- Illegal dims R=0,C=2, then R=5,C=1 (MAX_R=4) -> dim_err pulses once each; out_valid stays 0; load_ready stays 1.
- Change rslt_flat and R/C on the cycle after a 2x2 acceptance -> the stream still outputs the originally captured values and dims.
- Assert RST_N=0 after the 2nd beat of a 4x4 stream, then release and load a 2x2 [[1,2],[3,4]] -> out_valid=0 during reset; next stream is exactly 1,2,3,4 with correct indices.
